// File: rtl/state_transition_sequencer_pkg.sv
// state_transition_sequencer_pkg
//   Shared constants and helpers for the state transition sequencer:
//   state codes, MU levels, Ca2+ threshold levels (Q14), the sequencer FSM
//   encoding and the per-state target lookup.
package state_transition_sequencer_pkg;

  localparam logic [2:0] STATE_NORMAL      = 3'd0;
  localparam logic [2:0] STATE_ANESTHESIA  = 3'd1;
  localparam logic [2:0] STATE_PSYCHEDELIC = 3'd2;
  localparam logic [2:0] STATE_FLOW        = 3'd3;
  localparam logic [2:0] STATE_MEDITATION  = 3'd4;

  localparam logic [15:0] MU_WEAK     = 16'd1;
  localparam logic [15:0] MU_HALF     = 16'd2;
  localparam logic [15:0] MU_FULL     = 16'd4;
  localparam logic [15:0] MU_ENHANCED = 16'd6;

  localparam logic [15:0] CA_LOW  = 16'd4096;
  localparam logic [15:0] CA_MED  = 16'd6144;
  localparam logic [15:0] CA_BASE = 16'd8192;
  localparam logic [15:0] CA_HIGH = 16'd12288;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RAMP,
    SEQ_DWELL
  } seq_state_e;

  typedef struct packed {
    logic [15:0] theta;
    logic [15:0] l6;
    logic [15:0] l5b;
    logic [15:0] l5a;
    logic [15:0] l4;
    logic [15:0] l23;
    logic [15:0] ca;
  } targets_t;

  // Unused codes 5..7 collapse onto NORMAL.
  function automatic logic [2:0] sanitize_code(input logic [2:0] code);
    return (code > STATE_MEDITATION) ? STATE_NORMAL : code;
  endfunction

  function automatic targets_t target_lookup(input logic [2:0] code);
    targets_t t;
    t = '{MU_FULL, MU_FULL, MU_FULL, MU_FULL, MU_FULL, MU_FULL, CA_BASE};
    case (code)
      STATE_ANESTHESIA:
        t = '{MU_HALF, MU_ENHANCED, MU_HALF, MU_HALF, MU_WEAK, MU_WEAK, CA_HIGH};
      STATE_PSYCHEDELIC:
        t = '{MU_FULL, MU_HALF, MU_FULL, MU_FULL, MU_ENHANCED, MU_ENHANCED, CA_LOW};
      STATE_FLOW:
        t = '{MU_FULL, MU_HALF, MU_ENHANCED, MU_ENHANCED, MU_FULL, MU_FULL, CA_BASE};
      STATE_MEDITATION:
        t = '{MU_FULL, MU_FULL, MU_HALF, MU_HALF, MU_HALF, MU_HALF, CA_MED};
      default: ;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/state_transition_sequencer_if.sv
// state_transition_sequencer_if
//   Request handshake between the host/state-select logic and the sequencer.
//   req_state : requested state code
//   req_valid : request valid (master drives)
//   req_ready : pending slot empty (sequencer drives)
interface state_transition_sequencer_if;
  logic [2:0] req_state;
  logic       req_valid;
  logic       req_ready;

  modport master (output req_state, output req_valid, input req_ready);
  modport slave  (input req_state, input req_valid, output req_ready);
endinterface

// File: rtl/state_transition_sequencer_ramp_stepper.sv
// ramp_stepper
//   Single channel that moves a signed value toward a target by at most STEP
//   per enabled cycle, landing exactly on the target without overshoot.
//   clk, rst_n     : clock, synchronous active-low reset (value -> RESET_VAL)
//   step_en        : advance one step this cycle
//   target         : value to approach
//   value          : current registered value
//   next_at_target : value will equal target after this edge
module ramp_stepper #(
  parameter int unsigned WIDTH     = 18,
  parameter int unsigned STEP      = 1,
  parameter int          RESET_VAL = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    step_en,
  input  logic signed [WIDTH-1:0] target,
  output logic signed [WIDTH-1:0] value,
  output logic                    next_at_target
);

  localparam logic signed [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  logic signed [WIDTH-1:0] value_q, value_d;
  logic signed [WIDTH:0]   diff;

  always_comb begin
    diff    = {target[WIDTH-1], target} - {value_q[WIDTH-1], value_q};
    value_d = value_q;
    if (step_en) begin
      if (diff > STEP_EXT)       value_d = value_q + WIDTH'(STEP);
      else if (diff < -STEP_EXT) value_d = value_q - WIDTH'(STEP);
      else                       value_d = target;
    end
    next_at_target = (value_d == target);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) value_q <= WIDTH'(RESET_VAL);
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/state_transition_sequencer.sv
// state_transition_sequencer
//   Accepts consciousness-state change requests, ramps the six per-layer MU
//   values and the Ca2+ threshold toward the new targets on clk_en, then holds
//   a minimum dwell before the next transition. One request is buffered.
//   Optional macro STATE_SEQ_STATS_EN adds transition_count (saturating).
//   Ports:
//     clk, rst_n     : clock, synchronous active-low reset
//     clk_en         : update strobe; ramp and dwell advance only on it
//     req_if         : request handshake (slave)
//     state_current  : last fully reached state
//     busy           : FSM not idle
//     mu_dt_*        : ramped MU values
//     ca_threshold   : ramped Ca2+ threshold (Q FRAC)
//     transition_count : completed transitions (only with STATE_SEQ_STATS_EN)
module state_transition_sequencer
  import state_transition_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH       = 18,
  parameter int unsigned FRAC        = 14,
  parameter int unsigned CA_STEP     = 16,
  parameter int unsigned DWELL_TICKS = 400
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  state_transition_sequencer_if.slave req_if,
  output logic [2:0]              state_current,
  output logic                    busy,
  output logic signed [WIDTH-1:0] mu_dt_theta,
  output logic signed [WIDTH-1:0] mu_dt_l6,
  output logic signed [WIDTH-1:0] mu_dt_l5b,
  output logic signed [WIDTH-1:0] mu_dt_l5a,
  output logic signed [WIDTH-1:0] mu_dt_l4,
  output logic signed [WIDTH-1:0] mu_dt_l23,
`ifdef STATE_SEQ_STATS_EN
  output logic [15:0]             transition_count,
`endif
  output logic signed [WIDTH-1:0] ca_threshold
);

  localparam int unsigned DW = $clog2(DWELL_TICKS + 1);
  localparam int unsigned NCH = 7;

  seq_state_e    state_q, state_d;
  logic          pending_valid_q, pending_valid_d;
  logic [2:0]    pending_code_q, pending_code_d;
  logic [2:0]    target_code_q, target_code_d;
  logic [2:0]    state_current_q, state_current_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          ramp_done;

  targets_t                tgt;
  logic signed [WIDTH-1:0] tgt_val [NCH];
  logic signed [WIDTH-1:0] ch_val  [NCH];
  logic [NCH-1:0]          ch_at;
  logic                    step_en;

  // FRAC documents the Q-format of ca_threshold; targets are already scaled.
  logic unused_frac;
  assign unused_frac = (FRAC == 0);

  assign tgt     = target_lookup(target_code_q);
  assign step_en = (state_q == SEQ_RAMP) && clk_en;

  always_comb begin
    tgt_val[0] = $signed(WIDTH'(tgt.theta));
    tgt_val[1] = $signed(WIDTH'(tgt.l6));
    tgt_val[2] = $signed(WIDTH'(tgt.l5b));
    tgt_val[3] = $signed(WIDTH'(tgt.l5a));
    tgt_val[4] = $signed(WIDTH'(tgt.l4));
    tgt_val[5] = $signed(WIDTH'(tgt.l23));
    tgt_val[6] = $signed(WIDTH'(tgt.ca));
  end

  // Channels 0..5 are MU (unit step), channel 6 is the Ca2+ threshold.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ramp_stepper #(
      .WIDTH    (WIDTH),
      .STEP     ((i == NCH-1) ? CA_STEP : 1),
      .RESET_VAL((i == NCH-1) ? int'(CA_BASE) : int'(MU_FULL))
    ) u_step (
      .clk           (clk),
      .rst_n         (rst_n),
      .step_en       (step_en),
      .target        (tgt_val[i]),
      .value         (ch_val[i]),
      .next_at_target(ch_at[i])
    );
  end

  always_comb begin
    state_d         = state_q;
    pending_valid_d = pending_valid_q;
    pending_code_d  = pending_code_q;
    target_code_d   = target_code_q;
    state_current_d = state_current_q;
    dwell_d         = dwell_q;
    ramp_done       = 1'b0;

    // Accept and consume are exclusive: accept needs an empty slot.
    if (req_if.req_valid && !pending_valid_q) begin
      pending_valid_d = 1'b1;
      pending_code_d  = sanitize_code(req_if.req_state);
    end

    case (state_q)
      SEQ_IDLE: begin
        if (pending_valid_q) begin
          pending_valid_d = 1'b0;
          if (pending_code_q != state_current_q) begin
            target_code_d = pending_code_q;
            state_d       = SEQ_RAMP;
          end
        end
      end
      SEQ_RAMP: begin
        // Finish on the tick whose update lands every channel on target.
        if (clk_en && (&ch_at)) begin
          state_current_d = target_code_q;
          dwell_d         = DW'(DWELL_TICKS - 1);
          state_d         = SEQ_DWELL;
          ramp_done       = 1'b1;
        end
      end
      SEQ_DWELL: begin
        if (clk_en) begin
          if (dwell_q == '0) state_d = SEQ_IDLE;
          else               dwell_d = dwell_q - DW'(1);
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= SEQ_IDLE;
      pending_valid_q <= 1'b0;
      pending_code_q  <= STATE_NORMAL;
      target_code_q   <= STATE_NORMAL;
      state_current_q <= STATE_NORMAL;
      dwell_q         <= '0;
    end else begin
      state_q         <= state_d;
      pending_valid_q <= pending_valid_d;
      pending_code_q  <= pending_code_d;
      target_code_q   <= target_code_d;
      state_current_q <= state_current_d;
      dwell_q         <= dwell_d;
    end
  end

`ifdef STATE_SEQ_STATS_EN
  logic [15:0] transition_count_q, transition_count_d;

  always_comb begin
    transition_count_d = transition_count_q;
    if (ramp_done && (transition_count_q != '1))
      transition_count_d = transition_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) transition_count_q <= '0;
    else        transition_count_q <= transition_count_d;
  end

  assign transition_count = transition_count_q;
`else
  logic unused_ramp_done;
  assign unused_ramp_done = ramp_done;
`endif

  assign req_if.req_ready = !pending_valid_q;
  assign busy             = (state_q != SEQ_IDLE);
  assign state_current    = state_current_q;
  assign mu_dt_theta      = ch_val[0];
  assign mu_dt_l6         = ch_val[1];
  assign mu_dt_l5b        = ch_val[2];
  assign mu_dt_l5a        = ch_val[3];
  assign mu_dt_l4         = ch_val[4];
  assign mu_dt_l23        = ch_val[5];
  assign ca_threshold     = ch_val[6];

endmodule
